// File: rtl/decode_stage_pkg.sv
// Shared decode definitions: opcodes, format encoding, control word and queued packet layout.
package decode_stage_pkg;

  localparam int unsigned INST_W = 32;
  localparam int unsigned REG_W  = 5;
  localparam int unsigned FMT_W  = 6;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  // One-hot instruction format, selects the immediate layout.
  localparam logic [FMT_W-1:0] FMT_R = 6'b000001;
  localparam logic [FMT_W-1:0] FMT_I = 6'b000010;
  localparam logic [FMT_W-1:0] FMT_S = 6'b000100;
  localparam logic [FMT_W-1:0] FMT_B = 6'b001000;
  localparam logic [FMT_W-1:0] FMT_U = 6'b010000;
  localparam logic [FMT_W-1:0] FMT_J = 6'b100000;

  // One-hot writeback source.
  localparam logic [3:0] RD_ALU = 4'b0001;
  localparam logic [3:0] RD_MEM = 4'b0010;
  localparam logic [3:0] RD_PC4 = 4'b0100;
  localparam logic [3:0] RD_IMM = 4'b1000;

  typedef struct packed {
    logic       op1_sel;     // 0: rs1, 1: pc
    logic       op2_sel;     // 0: rs2, 1: imm
    logic [2:0] alu_opsel;
    logic       sub;
    logic       uns;
    logic       arith;
    logic       branch;
    logic       jump;
    logic       br_eq;
    logic       br_uns;
    logic       br_inv;
    logic       dmem_ren;
    logic       dmem_wen;
    logic [1:0] dmem_align;
    logic       memb;
    logic       memh;
    logic       memw;
    logic       memu;
    logic [3:0] rd_sel;
    logic       pc_sel;
    logic       mul;
    logic [2:0] mul_op;
  } ctrl_t;

  localparam int unsigned CTRL_W = $bits(ctrl_t);

  typedef struct packed {
    ctrl_t             ctrl;
    logic [31:0]       imm;
    logic [REG_W-1:0]  rs1;
    logic [REG_W-1:0]  rs2;
    logic [REG_W-1:0]  rd;
    logic              legal;
    logic              halt;
  } dec_t;

endpackage

// File: rtl/decode_comb.sv
// Combinational RV32I(+M) single-instruction decoder with immediate generation.
module decode_comb
  import decode_stage_pkg::*;
#(
  parameter bit EN_M = 1'b0
) (
  input  logic [INST_W-1:0] inst,
  output logic [CTRL_W-1:0] ctrl,
  output logic [31:0]       imm,
  output logic [REG_W-1:0]  rs1,
  output logic [REG_W-1:0]  rs2,
  output logic [REG_W-1:0]  rd,
  output logic              legal,
  output logic              halt
);

  logic [6:0]       opc;
  logic [2:0]       f3;
  logic [6:0]       f7;
  logic [FMT_W-1:0] fmt;
  ctrl_t            c;
  logic             use_rs1;
  logic             use_rs2;
  logic             use_rd;

  assign opc = inst[6:0];
  assign f3  = inst[14:12];
  assign f7  = inst[31:25];

  // Control, legality and register usage per opcode.
  always_comb begin
    c       = '0;
    fmt     = '0;
    legal   = 1'b0;
    halt    = 1'b0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    use_rd  = 1'b0;
    case (opc)
      OPC_LUI: begin
        legal    = 1'b1;
        fmt      = FMT_U;
        use_rd   = 1'b1;
        c.rd_sel = RD_IMM;
      end
      OPC_AUIPC: begin
        legal     = 1'b1;
        fmt       = FMT_U;
        use_rd    = 1'b1;
        c.op1_sel = 1'b1;
        c.op2_sel = 1'b1;
        c.rd_sel  = RD_ALU;
      end
      OPC_JAL: begin
        legal     = 1'b1;
        fmt       = FMT_J;
        use_rd    = 1'b1;
        c.op1_sel = 1'b1;
        c.op2_sel = 1'b1;
        c.jump    = 1'b1;
        c.pc_sel  = 1'b1;
        c.rd_sel  = RD_PC4;
      end
      OPC_JALR: begin
        legal     = (f3 == 3'b000);
        fmt       = FMT_I;
        use_rs1   = 1'b1;
        use_rd    = 1'b1;
        c.op2_sel = 1'b1;
        c.jump    = 1'b1;
        c.pc_sel  = 1'b1;
        c.rd_sel  = RD_PC4;
      end
      OPC_BRANCH: begin
        legal     = (f3[2:1] != 2'b01);
        fmt       = FMT_B;
        use_rs1   = 1'b1;
        use_rs2   = 1'b1;
        c.op1_sel = 1'b1;
        c.op2_sel = 1'b1;
        c.branch  = 1'b1;
        c.br_eq   = ~f3[2];
        c.br_uns  = f3[1];
        c.br_inv  = f3[0];
      end
      OPC_LOAD: begin
        legal        = (f3[1:0] != 2'b11) && !(f3[2] && f3[1]);
        fmt          = FMT_I;
        use_rs1      = 1'b1;
        use_rd       = 1'b1;
        c.op2_sel    = 1'b1;
        c.dmem_ren   = 1'b1;
        c.dmem_align = f3[1:0];
        c.memb       = (f3[1:0] == 2'b00);
        c.memh       = (f3[1:0] == 2'b01);
        c.memw       = (f3[1:0] == 2'b10);
        c.memu       = f3[2];
        c.rd_sel     = RD_MEM;
      end
      OPC_STORE: begin
        legal        = !f3[2] && (f3[1:0] != 2'b11);
        fmt          = FMT_S;
        use_rs1      = 1'b1;
        use_rs2      = 1'b1;
        c.op2_sel    = 1'b1;
        c.dmem_wen   = 1'b1;
        c.dmem_align = f3[1:0];
        c.memb       = (f3[1:0] == 2'b00);
        c.memh       = (f3[1:0] == 2'b01);
        c.memw       = (f3[1:0] == 2'b10);
      end
      OPC_OPIMM: begin
        fmt         = FMT_I;
        use_rs1     = 1'b1;
        use_rd      = 1'b1;
        c.op2_sel   = 1'b1;
        c.alu_opsel = f3;
        c.uns       = (f3 == 3'b011);
        c.rd_sel    = RD_ALU;
        case (f3)
          3'b001: legal = (f7 == 7'b0000000);
          3'b101: begin
            legal   = (f7 == 7'b0000000) || (f7 == 7'b0100000);
            c.arith = f7[5];
          end
          default: legal = 1'b1;
        endcase
      end
      OPC_OP: begin
        fmt      = FMT_R;
        use_rs1  = 1'b1;
        use_rs2  = 1'b1;
        use_rd   = 1'b1;
        c.rd_sel = RD_ALU;
        if (f7 == 7'b0000000) begin
          legal       = 1'b1;
          c.alu_opsel = f3;
          c.uns       = (f3 == 3'b011);
        end else if (f7 == 7'b0100000) begin
          legal       = (f3 == 3'b000) || (f3 == 3'b101);
          c.alu_opsel = f3;
          c.sub       = (f3 == 3'b000);
          c.arith     = (f3 == 3'b101);
        end else if ((f7 == 7'b0000001) && EN_M) begin
          legal    = 1'b1;
          c.mul    = 1'b1;
          c.mul_op = f3;
        end
      end
      OPC_FENCE: begin
        legal = (f3 == 3'b000);
        fmt   = FMT_I;
      end
      OPC_SYSTEM: begin
        // Only ecall and ebreak; CSR access is outside the base ISA.
        legal = (inst == 32'h0000_0073) || (inst == 32'h0010_0073);
        halt  = (inst == 32'h0010_0073);
      end
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    imm = '0;
    case (fmt)
      FMT_I:   imm = {{20{inst[31]}}, inst[31:20]};
      FMT_S:   imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      FMT_B:   imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      FMT_U:   imm = {inst[31:12], 12'b0};
      FMT_J:   imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

  assign ctrl = c;
  assign rs1  = use_rs1 ? inst[19:15] : '0;
  assign rs2  = use_rs2 ? inst[24:20] : '0;
  assign rd   = use_rd  ? inst[11:7]  : '0;

endmodule

// File: rtl/decode_stage.sv
// Queued decode stage: decodes at enqueue, buffers packets in a small FIFO,
// stops accepting fetch after a halting/illegal packet and supports flush.
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned PC_W  = 32,
  parameter bit          EN_M  = 1'b0
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_flush,
  input  logic                       i_f_valid,
  output logic                       o_f_ready,
  input  logic [31:0]                i_f_inst,
  input  logic [PC_W-1:0]            i_f_pc,
  output logic                       o_d_valid,
  input  logic                       i_d_ready,
  output logic [PC_W-1:0]            o_d_pc,
  output logic [CTRL_W-1:0]          o_d_ctrl,
  output logic [31:0]                o_d_imm,
  output logic [REG_W-1:0]           o_d_rs1,
  output logic [REG_W-1:0]           o_d_rs2,
  output logic [REG_W-1:0]           o_d_rd,
  output logic                       o_d_legal,
  output logic                       o_d_halt,
  output logic                       o_halted,
  output logic [$clog2(DEPTH):0]     o_occupancy
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_HALTED} state_t;

  state_t            state;
  state_t            state_nxt;
  dec_t              mem    [DEPTH];
  logic [PC_W-1:0]   pc_mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  count_nxt;
  logic              ready_nxt;
  logic              valid_nxt;
  logic              push;
  logic              pop;
  logic              stop;
  logic              head_stop;
  dec_t              dec_in;
  dec_t              head;

  logic [CTRL_W-1:0] dec_ctrl;
  logic [31:0]       dec_imm;
  logic [REG_W-1:0]  dec_rs1;
  logic [REG_W-1:0]  dec_rs2;
  logic [REG_W-1:0]  dec_rd;
  logic              dec_legal;
  logic              dec_halt;

  decode_comb #(
    .EN_M (EN_M)
  ) u_decode (
    .inst  (i_f_inst),
    .ctrl  (dec_ctrl),
    .imm   (dec_imm),
    .rs1   (dec_rs1),
    .rs2   (dec_rs2),
    .rd    (dec_rd),
    .legal (dec_legal),
    .halt  (dec_halt)
  );

  always_comb begin
    dec_in.ctrl  = ctrl_t'(dec_ctrl);
    dec_in.imm   = dec_imm;
    dec_in.rs1   = dec_rs1;
    dec_in.rs2   = dec_rs2;
    dec_in.rd    = dec_rd;
    dec_in.legal = dec_legal;
    dec_in.halt  = dec_halt;
  end

  assign head      = mem[rd_ptr];
  assign push      = i_f_valid & o_f_ready & ~i_flush;
  assign pop       = o_d_valid & i_d_ready & ~i_flush;
  assign stop      = ~dec_in.legal | dec_in.halt;
  assign head_stop = ~head.legal | head.halt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= S_RUN;
    else       state <= state_nxt;
  end

  // Next state, next occupancy and the registered handshake outputs derived from them.
  always_comb begin
    state_nxt = state;
    count_nxt = count;
    if (i_flush)            count_nxt = '0;
    else if (push && !pop)  count_nxt = count + CNT_W'(1);
    else if (pop && !push)  count_nxt = count - CNT_W'(1);
    case (state)
      S_RUN:    if (push && stop) state_nxt = S_DRAIN;
      S_DRAIN: begin
        if (i_flush)               state_nxt = S_RUN;
        else if (pop && head_stop) state_nxt = S_HALTED;
      end
      S_HALTED: state_nxt = S_HALTED;
      default:  state_nxt = S_RUN;
    endcase
    ready_nxt = (state_nxt == S_RUN) && (count_nxt < CNT_W'(DEPTH));
    valid_nxt = (count_nxt != '0);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      o_f_ready <= 1'b0;
      o_d_valid <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i]    <= '0;
        pc_mem[i] <= '0;
      end
    end else begin
      count     <= count_nxt;
      o_f_ready <= ready_nxt;
      o_d_valid <= valid_nxt;
      if (i_flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) begin
          mem[wr_ptr]    <= dec_in;
          pc_mem[wr_ptr] <= i_f_pc;
          wr_ptr         <= wr_ptr + PTR_W'(1);
        end
        if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      end
    end
  end

  assign o_d_pc      = pc_mem[rd_ptr];
  assign o_d_ctrl    = head.ctrl;
  assign o_d_imm     = head.imm;
  assign o_d_rs1     = head.rs1;
  assign o_d_rs2     = head.rs2;
  assign o_d_rd      = head.rd;
  assign o_d_legal   = head.legal;
  assign o_d_halt    = head.halt;
  assign o_halted    = (state == S_HALTED);
  assign o_occupancy = count;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage; dut0 has EN_M=0, dut1 has EN_M=1 on shared stimulus.
module tb_decode_stage;
  import decode_stage_pkg::*;

  localparam int unsigned DEPTH = 2;
  localparam int unsigned PC_W  = 32;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  localparam logic [31:0] ADDI   = 32'h0050_0093;
  localparam logic [31:0] MUL    = 32'h0220_81B3;
  localparam logic [31:0] SW     = 32'h0020_A423;
  localparam logic [31:0] EBREAK = 32'h0010_0073;

  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  logic              f_valid;
  logic [31:0]       inst;
  logic [PC_W-1:0]   pc;
  logic              d_ready;

  logic              f_ready0, d_valid0, legal0, halt0, halted0;
  logic [PC_W-1:0]   d_pc0;
  logic [CTRL_W-1:0] d_ctrl0;
  logic [31:0]       imm0;
  logic [4:0]        rs1_0, rs2_0, rd0;
  logic [CNT_W-1:0]  occ0;

  logic              f_ready1, d_valid1, legal1, halt1, halted1;
  logic [PC_W-1:0]   d_pc1;
  logic [CTRL_W-1:0] d_ctrl1;
  logic [31:0]       imm1;
  logic [4:0]        rs1_1, rs2_1, rd1;
  logic [CNT_W-1:0]  occ1;

  ctrl_t c0, c1;
  assign c0 = ctrl_t'(d_ctrl0);
  assign c1 = ctrl_t'(d_ctrl1);

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  decode_stage #(.DEPTH(DEPTH), .PC_W(PC_W), .EN_M(1'b0)) dut0 (
    .i_clk(clk), .i_rst(rst), .i_flush(flush),
    .i_f_valid(f_valid), .o_f_ready(f_ready0), .i_f_inst(inst), .i_f_pc(pc),
    .o_d_valid(d_valid0), .i_d_ready(d_ready), .o_d_pc(d_pc0), .o_d_ctrl(d_ctrl0),
    .o_d_imm(imm0), .o_d_rs1(rs1_0), .o_d_rs2(rs2_0), .o_d_rd(rd0),
    .o_d_legal(legal0), .o_d_halt(halt0), .o_halted(halted0), .o_occupancy(occ0)
  );

  decode_stage #(.DEPTH(DEPTH), .PC_W(PC_W), .EN_M(1'b1)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_flush(flush),
    .i_f_valid(f_valid), .o_f_ready(f_ready1), .i_f_inst(inst), .i_f_pc(pc),
    .o_d_valid(d_valid1), .i_d_ready(d_ready), .o_d_pc(d_pc1), .o_d_ctrl(d_ctrl1),
    .o_d_imm(imm1), .o_d_rs1(rs1_1), .o_d_rs2(rs2_1), .o_d_rd(rd1),
    .o_d_legal(legal1), .o_d_halt(halt1), .o_halted(halted1), .o_occupancy(occ1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst     = 1'b1;
    f_valid = 1'b0;
    flush   = 1'b0;
    d_ready = 1'b0;
    step();
    rst = 1'b0;
    step();
  endtask

  // Decode vectors: inst, imm, rd, rs1, rs2
  logic [31:0] vec_inst [5] = '{32'h1234_52B7, 32'hFE20_8EE3, 32'hFF81_A203, 32'h0010_00EF, 32'h4033_D313};
  logic [31:0] vec_imm  [5] = '{32'h1234_5000, 32'hFFFF_FFFC, 32'hFFFF_FFF8, 32'h0000_0800, 32'h0000_0403};
  logic [4:0]  vec_rd   [5] = '{5'd5, 5'd0, 5'd4, 5'd1, 5'd6};
  logic [4:0]  vec_rs1  [5] = '{5'd0, 5'd1, 5'd3, 5'd0, 5'd7};
  logic [4:0]  vec_rs2  [5] = '{5'd0, 5'd2, 5'd0, 5'd0, 5'd0};

  initial begin
    rst = 1'b1; flush = 1'b0; f_valid = 1'b0; inst = '0; pc = '0; d_ready = 1'b0;
    step(); step();
    check("rst_valid",  32'(d_valid0), 32'd0);
    check("rst_ready",  32'(f_ready0), 32'd0);
    check("rst_occ",    32'(occ0),     32'd0);
    check("rst_halted", 32'(halted0),  32'd0);
    rst = 1'b0;
    step();
    check("rel_ready", 32'(f_ready0), 32'd1);

    // Reset asserted mid-stream with two packets queued
    inst = ADDI; pc = 32'h100; f_valid = 1'b1;
    step(); step();
    check("mid_occ", 32'(occ0), 32'd2);
    rst = 1'b1;
    #1;
    check("mid_rst_valid",  32'(d_valid0), 32'd0);
    check("mid_rst_occ",    32'(occ0),     32'd0);
    check("mid_rst_halted", 32'(halted0),  32'd0);
    f_valid = 1'b0;
    step();
    rst = 1'b0;
    step();
    check("mid_rel_ready", 32'(f_ready0), 32'd1);

    // Single addi, then 8 back-to-back packets
    d_ready = 1'b1; inst = ADDI; pc = 32'h100; f_valid = 1'b1;
    step();
    f_valid = 1'b0;
    check("addi_valid",  32'(d_valid0),  32'd1);
    check("addi_pc",     d_pc0,          32'h100);
    check("addi_imm",    imm0,           32'd5);
    check("addi_rd",     32'(rd0),       32'd1);
    check("addi_rs1",    32'(rs1_0),     32'd0);
    check("addi_rs2",    32'(rs2_0),     32'd0);
    check("addi_rd_sel", 32'(c0.rd_sel), 32'b0001);
    check("addi_legal",  32'(legal0),    32'd1);
    step();
    check("addi_popped", 32'(d_valid0), 32'd0);
    for (int k = 0; k < 8; k++) begin
      pc = 32'h200 + 32'(4 * k); f_valid = 1'b1;
      step();
      check($sformatf("b2b_pc%0d", k),    d_pc0,          32'h200 + 32'(4 * k));
      check($sformatf("b2b_valid%0d", k), 32'(d_valid0),  32'd1);
    end
    f_valid = 1'b0;
    step();
    check("b2b_drained_valid", 32'(d_valid0), 32'd0);
    check("b2b_drained_occ",   32'(occ0),     32'd0);

    // Decode table
    for (int k = 0; k < 5; k++) begin
      inst = vec_inst[k]; pc = 32'h700 + 32'(4 * k); f_valid = 1'b1;
      step();
      check($sformatf("vec%0d_imm", k),   imm0,          vec_imm[k]);
      check($sformatf("vec%0d_rd", k),    32'(rd0),      32'(vec_rd[k]));
      check($sformatf("vec%0d_rs1", k),   32'(rs1_0),    32'(vec_rs1[k]));
      check($sformatf("vec%0d_rs2", k),   32'(rs2_0),    32'(vec_rs2[k]));
      check($sformatf("vec%0d_legal", k), 32'(legal0),   32'd1);
    end
    check("srai_arith", 32'(c0.arith), 32'd1);
    f_valid = 1'b0;
    step();

    // Full queue and ordering
    reset_dut();
    inst = ADDI; f_valid = 1'b1; pc = 32'h300;
    step();
    check("fill1_ready", 32'(f_ready0), 32'd1);
    pc = 32'h304;
    step();
    pc = 32'h308;
    step();
    check("full_occ",   32'(occ0),     32'd2);
    check("full_ready", 32'(f_ready0), 32'd0);
    check("full_head",  d_pc0,         32'h300);
    d_ready = 1'b1;
    step();
    check("order_pc1", d_pc0,      32'h304);
    check("order_occ", 32'(occ0),  32'd1);
    step();
    check("order_pc2", d_pc0,      32'h308);
    f_valid = 1'b0;
    step();
    check("order_empty", 32'(d_valid0), 32'd0);

    // mul: illegal without M, legal with M
    reset_dut();
    inst = MUL; pc = 32'h400; f_valid = 1'b1;
    step();
    f_valid = 1'b0;
    check("mul0_valid", 32'(d_valid0),  32'd1);
    check("mul0_legal", 32'(legal0),    32'd0);
    check("mul0_ready", 32'(f_ready0),  32'd0);
    check("mul1_legal", 32'(legal1),    32'd1);
    check("mul1_mul",   32'(c1.mul),    32'd1);
    check("mul1_op",    32'(c1.mul_op), 32'd0);
    check("mul1_rd",    32'(rd1),       32'd3);
    check("mul1_ready", 32'(f_ready1),  32'd1);
    d_ready = 1'b1;
    step();
    check("mul0_halted", 32'(halted0),  32'd1);
    check("mul0_ready2", 32'(f_ready0), 32'd0);
    check("mul1_halted", 32'(halted1),  32'd0);

    // ebreak behind sw, flushed before pop
    reset_dut();
    inst = SW; pc = 32'h500; f_valid = 1'b1;
    step();
    inst = EBREAK; pc = 32'h504;
    step();
    f_valid = 1'b0;
    check("drain_ready", 32'(f_ready0), 32'd0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush_occ",    32'(occ0),     32'd0);
    check("flush_valid",  32'(d_valid0), 32'd0);
    check("flush_ready",  32'(f_ready0), 32'd1);
    check("flush_halted", 32'(halted0),  32'd0);

    // ebreak behind sw, drained
    reset_dut();
    inst = SW; pc = 32'h500; f_valid = 1'b1;
    step();
    inst = EBREAK; pc = 32'h504;
    step();
    f_valid = 1'b0;
    check("sw_rd",   32'(rd0),         32'd0);
    check("sw_wen",  32'(c0.dmem_wen), 32'd1);
    check("sw_imm",  imm0,             32'd8);
    check("sw_rs2",  32'(rs2_0),       32'd2);
    d_ready = 1'b1;
    step();
    check("ebreak_halt",   32'(halt0),   32'd1);
    check("ebreak_legal",  32'(legal0),  32'd1);
    check("ebreak_halted", 32'(halted0), 32'd0);
    step();
    check("halted",        32'(halted0),  32'd1);
    check("halted_valid",  32'(d_valid0), 32'd0);
    check("halted_ready",  32'(f_ready0), 32'd0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("halted_flush", 32'(halted0), 32'd1);

    // Flush coincident with push and pop
    reset_dut();
    d_ready = 1'b1; inst = ADDI; pc = 32'h600; f_valid = 1'b1;
    step();
    check("pre_flush_occ", 32'(occ0), 32'd1);
    pc = 32'h604; flush = 1'b1;
    step();
    flush = 1'b0; f_valid = 1'b0;
    check("coflush_occ",   32'(occ0),     32'd0);
    check("coflush_valid", 32'(d_valid0), 32'd0);
    step();
    check("coflush_occ2",   32'(occ0),     32'd0);
    check("coflush_valid2", 32'(d_valid0), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
